// File: rtl/calculator_pkg.sv
// Shared constants and encodings for the calculator core and its iterative mul/div engine.
package calculator_pkg;

    localparam int CALC_WIDTH = 16;
    localparam int CALC_ITER  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

endpackage

// File: rtl/calculator_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one hi:lo shift register pair.
// done/result/overflow reflect the final iteration so the caller can capture them on that same edge.
module calculator_muldiv
    import calculator_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH,
    parameter int ITER  = CALC_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CNT_W = $clog2(ITER);

    logic             div_mode_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] opd_r;
    logic [CNT_W-1:0] count_r;
    logic             busy_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   rem_diff_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;

    // One iteration step; for division, bit WIDTH of the difference is the borrow.
    always_comb begin
        mul_sum_s  = {1'b0, hi_r} + {1'b0, opd_r};
        rem_sh_s   = {hi_r, lo_r[WIDTH-1]};
        rem_diff_s = rem_sh_s - {1'b0, opd_r};
        hi_nxt_s   = hi_r;
        lo_nxt_s   = lo_r;
        if (div_mode_r) begin
            if (!rem_diff_s[WIDTH]) begin
                hi_nxt_s = rem_diff_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_s = rem_sh_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_r[0]) begin
                hi_nxt_s = mul_sum_s[WIDTH:1];
                lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
            end else begin
                hi_nxt_s = {1'b0, hi_r[WIDTH-1:1]};
                lo_nxt_s = {hi_r[0], lo_r[WIDTH-1:1]};
            end
        end
    end

    // Operand capture, iteration counter and shift register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_mode_r <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
            opd_r      <= '0;
            count_r    <= '0;
            busy_r     <= 1'b0;
        end else if (start) begin
            div_mode_r <= (op == OP_DIV);
            hi_r       <= '0;
            lo_r       <= a;
            opd_r      <= b;
            count_r    <= '0;
            busy_r     <= 1'b1;
        end else if (busy_r) begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
            if (count_r == CNT_W'(ITER - 1)) begin
                count_r <= '0;
                busy_r  <= 1'b0;
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = busy_r && (count_r == CNT_W'(ITER - 1));
    assign result   = lo_nxt_s;
    assign overflow = div_mode_r ? 1'b0 : (hi_nxt_s != '0);

endmodule

// File: rtl/calculator_core.sv
// Operand registers, load/start arbitration, add/sub and the top FSM of the calculator.
// All renderer-facing outputs are registers; C only changes when a final result is known.
module calculator_core
    import calculator_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH,
    parameter int ITER  = CALC_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             start,
    input  logic [1:0]       op_sel,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             flag,
    output logic             busy,
    output logic             done
);

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] c_r;
    logic             flag_r;
    logic             busy_r;
    logic             done_r;

    op_t              op_s;
    logic             any_load_s;
    logic             accept_s;
    logic             md_start_s;
    logic [WIDTH:0]   add_sum_s;
    logic [WIDTH-1:0] sub_diff_s;

    logic             md_busy_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_result_s;
    logic             md_overflow_s;

    // Start arbitration: loads win over start, and start is only honoured outside COMPUTE.
    always_comb begin
        op_s       = op_t'(op_sel);
        any_load_s = load_a | load_b;
        accept_s   = 1'b0;
        md_start_s = 1'b0;
        add_sum_s  = {1'b0, a_r} + {1'b0, b_r};
        sub_diff_s = a_r - b_r;
        if ((state_r != ST_COMPUTE) && start && !any_load_s) begin
            accept_s   = 1'b1;
            md_start_s = (op_s == OP_MUL) || ((op_s == OP_DIV) && (b_r != '0));
        end else begin
            accept_s   = 1'b0;
            md_start_s = 1'b0;
        end
    end

    calculator_muldiv #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start    (md_start_s),
        .op       (op_s),
        .a        (a_r),
        .b        (b_r),
        .busy     (md_busy_s),
        .done     (md_done_s),
        .result   (md_result_s),
        .overflow (md_overflow_s)
    );

    // Top FSM with registered operands, result, flag and handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            flag_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (any_load_s) begin
                        if (load_a) a_r <= sw;
                        if (load_b) b_r <= sw;
                        state_r <= ST_IDLE;
                    end else if (accept_s) begin
                        flag_r <= 1'b0;
                        case (op_s)
                            OP_ADD: begin
                                c_r     <= add_sum_s[WIDTH-1:0];
                                flag_r  <= add_sum_s[WIDTH];
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                            OP_SUB: begin
                                c_r     <= sub_diff_s;
                                flag_r  <= (a_r < b_r);
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                            OP_DIV: begin
                                if (b_r == '0) begin
                                    c_r     <= {WIDTH{1'b1}};
                                    flag_r  <= 1'b1;
                                    done_r  <= 1'b1;
                                    state_r <= ST_DONE;
                                end else begin
                                    busy_r  <= 1'b1;
                                    state_r <= ST_COMPUTE;
                                end
                            end
                            default: begin
                                busy_r  <= 1'b1;
                                state_r <= ST_COMPUTE;
                            end
                        endcase
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_COMPUTE: begin
                    done_r <= 1'b0;
                    if (md_done_s) begin
                        c_r     <= md_result_s;
                        flag_r  <= md_overflow_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (!md_busy_s) begin
                        // Engine lost its job: report an error instead of hanging in COMPUTE.
                        c_r     <= {WIDTH{1'b1}};
                        flag_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign A    = a_r;
    assign B    = b_r;
    assign C    = c_r;
    assign flag = flag_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_calculator_core.sv
// Table-driven bench for calculator_core plus hand sequences for COMPUTE lockout and mid-operation reset.
module tb_calculator_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic        load_a;
    logic        load_b;
    logic        start;
    logic [1:0]  op_sel;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] C;
    logic        flag;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    calculator_core dut (
        .clk    (clk),
        .reset  (reset),
        .sw     (sw),
        .load_a (load_a),
        .load_b (load_b),
        .start  (start),
        .op_sel (op_sel),
        .A      (A),
        .B      (B),
        .C      (C),
        .flag   (flag),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] c;
        logic        flag;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
        sw = a; load_a = 1'b1;
        step();
        load_a = 1'b0; sw = b; load_b = 1'b1;
        step();
        load_b = 1'b0;
    endtask

    // Pulses start and waits for done; lat counts cycles after the start cycle.
    task automatic run_op(input logic [1:0] op, input bit inject, output int lat, output int busy_cnt);
        op_sel = op; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat <= 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (inject && lat == 3) begin
                sw = 16'hAAAA; load_a = 1'b1; load_b = 1'b1; start = 1'b1; op_sel = 2'b00;
            end
            step();
            load_a = 1'b0; load_b = 1'b0; start = 1'b0;
            lat++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done after %0d cycles expected done", lat);
        end
    endtask

    initial begin
        int lat;
        int bcnt;

        vecs[0] = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1};
        vecs[1] = '{16'd5,    16'd9,    2'b01, 16'hFFFC, 1'b1, 1};
        vecs[2] = '{16'd9,    16'd5,    2'b01, 16'h0004, 1'b0, 1};
        vecs[3] = '{16'd300,  16'd300,  2'b10, 16'h5F90, 1'b1, 17};
        vecs[4] = '{16'd255,  16'd257,  2'b10, 16'hFFFF, 1'b0, 17};
        vecs[5] = '{16'd1000, 16'd7,    2'b11, 16'd142,  1'b0, 17};
        vecs[6] = '{16'd1000, 16'd0,    2'b11, 16'hFFFF, 1'b1, 1};
        vecs[7] = '{16'h1234, 16'h4321, 2'b00, 16'h5555, 1'b0, 1};
        vecs[8] = '{16'hFFFF, 16'h0001, 2'b11, 16'hFFFF, 1'b0, 17};
        vecs[9] = '{16'h0000, 16'hBEEF, 2'b10, 16'h0000, 1'b0, 17};

        reset = 1'b1; sw = 16'h0000; load_a = 1'b0; load_b = 1'b0; start = 1'b0; op_sel = 2'b00;
        step();
        step();
        reset = 1'b0;
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_C", C, 0);
        check("rst_flag", flag, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        for (int i = 0; i < 10; i++) begin
            load_ab(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_A", i), A, vecs[i].a);
            check($sformatf("v%0d_B", i), B, vecs[i].b);
            run_op(vecs[i].op, 1'b0, lat, bcnt);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bcnt, (vecs[i].lat == 17) ? 16 : 0);
            check($sformatf("v%0d_C", i), C, vecs[i].c);
            check($sformatf("v%0d_flag", i), flag, vecs[i].flag);
            step();
            check($sformatf("v%0d_done_pulse", i), done, 0);
            check($sformatf("v%0d_C_hold", i), C, vecs[i].c);
        end

        // Loads and start during COMPUTE are ignored.
        load_ab(16'd1000, 16'd7);
        run_op(2'b11, 1'b1, lat, bcnt);
        check("lock_lat", lat, 17);
        check("lock_A", A, 16'd1000);
        check("lock_B", B, 16'd7);
        check("lock_C", C, 16'd142);

        // Load together with start in DONE: load wins, no operation, C holds.
        sw = 16'h0042; load_a = 1'b1; start = 1'b1; op_sel = 2'b00;
        step();
        load_a = 1'b0; start = 1'b0;
        check("ldst_A", A, 16'h0042);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ldst_done%0d", k), done, 0);
            check($sformatf("ldst_busy%0d", k), busy, 0);
            step();
        end
        check("ldst_C", C, 16'd142);

        // Reset in the middle of a multiply.
        load_ab(16'd300, 16'd300);
        op_sel = 2'b10; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) step();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_A", A, 0);
        check("mrst_B", B, 0);
        check("mrst_C", C, 0);
        check("mrst_flag", flag, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        for (int k = 0; k < 12; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) begin
                check($sformatf("mrst_quiet%0d", k), {done, busy}, 0);
            end
            step();
        end
        check("mrst_C_end", C, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calculator_core.md
Name: calculator_core

Overview:
Arithmetic engine that directly feeds the VGA text renderer. It holds operand registers A and B, which are loaded from the board switches. It computes C = A op B for add, sub, mul and div, and raises flag on overflow or error. A, B, C and flag connect straight to the renderer's inputs. Mul and div are multi-cycle (shift-add and restoring division), so the core has a small FSM and a busy/done handshake toward the button front end.

Parameters:
WIDTH, 16, operand/result width; must match the renderer's 16-bit fields.
ITER, 16, iteration count for mul/div; must equal WIDTH.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
sw  input  WIDTH  operand value from the switches
load_a  input  1  one-cycle pulse (debounced upstream): A <= sw
load_b  input  1  one-cycle pulse: B <= sw
start  input  1  one-cycle pulse: begin the operation selected by op_sel
op_sel  input  2  00 add, 01 sub, 10 mul, 11 div (unsigned)
A  output  WIDTH  operand A register
B  output  WIDTH  operand B register
C  output  WIDTH  result register
flag  output  1  error/overflow; drives the renderer's red background
busy  output  1  high while in COMPUTE
done  output  1  one-cycle pulse when C/flag update

Behaviour:
- Reset (synchronous, active-high, any state including mid-COMPUTE): state=IDLE; A=B=C=0; flag=0; busy=0; done=0; iteration counter and scratch registers = 0.
- States: IDLE, COMPUTE, DONE (encoded in the shared package).
- IDLE/DONE:
  - load_a loads A; load_b loads B. Both together load the same sw into both.
  - start is accepted only when load_a=load_b=0 in the same cycle. If any load is present, the load wins and start is dropped.
  - Accepted start: op_sel is latched and flag is cleared on that edge.
  - Add/sub: the result is written on the start edge; state goes to DONE and done=1 on the next cycle (latency 1).
  - Mul/div: go to COMPUTE with counter=0.
  - Any load in DONE returns to IDLE. C and flag hold until the next accepted start.
- COMPUTE:
  - busy=1; load_a, load_b and start are ignored (A and B are frozen).
  - Exactly ITER cycles, one iteration per cycle. On the ITER-th edge C and flag are written and state goes to DONE, so done pulses ITER+1 cycles after the start cycle.
- DONE: done=1 for exactly one cycle (the first cycle in DONE). The state then holds in DONE with done=0.
- Add: C = (A+B) mod 2^WIDTH; flag = carry out.
- Sub: C = (A-B) mod 2^WIDTH; flag = (A<B).
- Mul: 2*WIDTH-bit shift-add product; C = low WIDTH bits; flag = (high WIDTH bits != 0).
- Div: C = quotient floor(A/B); remainder is discarded.
- Div with B=0: no iteration. C=all ones, flag=1, done the cycle after start (latency 1).
- Outputs A, B, C, flag and busy are registered with no combinational paths from inputs. The renderer samples them asynchronously to the frame, so there are no intermediate values on C: scratch registers are separate from C.

Decomposition:
- Package calculator_pkg holds:
  - state encoding (IDLE, COMPUTE, DONE)
  - op codes (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - the WIDTH constant
- One natural sub-module, calculator_muldiv: a counter-driven iterative multiplier/divider with inputs start/op/a/b and outputs busy/done/result/overflow. It reuses one shift register pair for both operations.
- calculator_core keeps the operand registers, load/start arbitration, add/sub and the top FSM.

Test Plan:
- Load A=0xFFFF, B=0x0001, op=add, start -> done 1 cycle later; C=0x0000, flag=1.
- Load A=5, B=9, op=sub -> C=0xFFFC, flag=1. Then A=9, B=5 sub -> C=4, flag=0.
- A=300, B=300, op=mul -> busy 16 cycles; done on cycle 17 after start; C=0x5F90, flag=1. Also A=255, B=257 -> C=0xFFFF, flag=0.
- A=1000, B=7, op=div -> done at cycle 17; C=142, flag=0. Then B=0 div -> done after 1 cycle; C=0xFFFF, flag=1.
- Pulse load_a/start during COMPUTE -> A unchanged, no restart. load_a together with start in IDLE -> A loaded, no operation.
- Assert reset at iteration 8 of mul -> next cycle: A=B=C=0, flag=0, busy=0, state IDLE, no done pulse.
